hs_queue: RTL and testbench



---
 rtl/hs_queue.sv | 80 ++++++++
 tb/tb_hs_queue.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_queue.sv
// hs_queue: circular FIFO with valid/ready on both ports, flush and status.
// All outputs are decoded from registered pointers and storage only.
module hs_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    enq_valid,
    output logic                    enq_ready,
    input  logic [DATA_WIDTH-1:0]   enq_data,
    output logic                    deq_valid,
    input  logic                    deq_ready,
    output logic [DATA_WIDTH-1:0]   deq_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic enq_fire;
    logic deq_fire;

    // MSB is the wrap bit: equal index with differing wrap means full
    assign empty = (head_q == tail_q);
    assign full  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0])
                && (head_q[IDX_W] != tail_q[IDX_W]);
    assign count = tail_q - head_q;

    assign enq_ready   = !full;
    assign deq_valid   = !empty;
    assign almost_full = (count >= AF_LVL);
    assign deq_data    = empty ? '0 : mem_q[head_q[IDX_W-1:0]];

    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = deq_valid && deq_ready;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        mem_d  = mem_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (enq_fire) begin
                mem_d[tail_q[IDX_W-1:0]] = enq_data;
                tail_d = tail_q + PTR_ONE;
            end
            if (deq_fire) begin
                head_d = head_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            mem_q  <= '{default: '0};
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: tb/tb_hs_queue.sv
// tb_hs_queue: scenario tasks plus randomized traffic against a queue model.
// Small configuration (8-bit, 4 deep, almost_full at 3).
module tb_hs_queue;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          enq_valid;
    logic          enq_ready;
    logic [DW-1:0] enq_data;
    logic          deq_valid;
    logic          deq_ready;
    logic [DW-1:0] deq_data;
    logic [2:0]    count;
    logic          full;
    logic          empty;
    logic          almost_full;

    int n_cmp;
    int n_bad;

    logic [DW-1:0] mq[$];

    hs_queue #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .AF_THRESH(AF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .enq_valid(enq_valid),
        .enq_ready(enq_ready),
        .enq_data(enq_data),
        .deq_valid(deq_valid),
        .deq_ready(deq_ready),
        .deq_data(deq_data),
        .count(count),
        .full(full),
        .empty(empty),
        .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] act_st();
        return {enq_ready, deq_valid, full, empty, almost_full, count, deq_data};
    endfunction

    // Expected outputs derived only from the model's occupancy and head
    function automatic logic [15:0] exp_st();
        int n;
        logic [2:0] c;
        logic [DW-1:0] h;
        n = mq.size();
        c = 3'(n);
        h = (n > 0) ? mq[0] : '0;
        return {n < DEPTH, n > 0, n == DEPTH, n == 0, n >= AF, c, h};
    endfunction

    // One clock edge: the model decides what fires from its own occupancy
    task automatic tick();
        bit ef;
        bit df;
        ef = enq_valid && (mq.size() < DEPTH);
        df = deq_ready && (mq.size() > 0);
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (df) void'(mq.pop_front());
            if (ef) mq.push_back(enq_data);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        flush = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        enq_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        enq_valid = 1'b1;
        enq_data = 8'hEE;
        deq_ready = 1'b1;
        tick();
        tick();
        idle_inputs();
        n_cmp++;
        if (act_st() !== 16'b1_0_0_1_0_000_00000000) begin
            n_bad++;
            $display("FAIL reset_state: got %b want %b",
                     act_st(), 16'b1_0_0_1_0_000_00000000);
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] vals [5];
        int want;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) begin
            enq_valid = 1'b1;
            enq_data = vals[i];
            tick();
            want = (i + 1 > DEPTH) ? DEPTH : i + 1;
            n_cmp++;
            if (count !== 3'(want) || almost_full !== (want >= AF)) begin
                n_bad++;
                $display("FAIL fill_%0d: count=%0d af=%b want count=%0d af=%b",
                         i, count, almost_full, want, want >= AF);
            end
        end
        enq_valid = 1'b0;
        n_cmp++;
        if (full !== 1'b1 || enq_ready !== 1'b0 || deq_data !== 8'h11) begin
            n_bad++;
            $display("FAIL fill_full: full=%b rdy=%b head=%h want 1 0 11",
                     full, enq_ready, deq_data);
        end
    endtask

    task automatic test_drain();
        logic [DW-1:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (deq_data !== vals[i] || deq_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL drain_%0d: data=%h valid=%b want %h 1",
                         i, deq_data, deq_valid, vals[i]);
            end
            tick();
        end
        deq_ready = 1'b0;
        n_cmp++;
        if (empty !== 1'b1 || deq_valid !== 1'b0 || deq_data !== 8'h00) begin
            n_bad++;
            $display("FAIL drain_empty: empty=%b valid=%b data=%h want 1 0 00",
                     empty, deq_valid, deq_data);
        end
    endtask

    task automatic test_back_to_back();
        enq_valid = 1'b1;
        enq_data = 8'h01;
        tick();
        enq_data = 8'h02;
        tick();
        deq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enq_data = 8'(8'hA0 + i);
            n_cmp++;
            if (deq_data !== mq[0]) begin
                n_bad++;
                $display("FAIL b2b_order_%0d: data=%h want %h", i, deq_data, mq[0]);
            end
            tick();
            n_cmp++;
            if (count !== 3'd2) begin
                n_bad++;
                $display("FAIL b2b_count_%0d: count=%0d want 2", i, count);
            end
        end
        enq_valid = 1'b0;
        n_cmp++;
        if (deq_data !== 8'hA8) begin
            n_bad++;
            $display("FAIL b2b_tail: data=%h want a8", deq_data);
        end
        tick();
        tick();
        deq_ready = 1'b0;
    endtask

    task automatic test_full_deq();
        enq_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enq_data = 8'(8'hC0 + i);
            tick();
        end
        enq_data = 8'hCF;
        deq_ready = 1'b1;
        tick();
        n_cmp++;
        if (count !== 3'd3 || enq_ready !== 1'b1 || deq_data !== 8'hC1) begin
            n_bad++;
            $display("FAIL full_deq: count=%0d rdy=%b head=%h want 3 1 c1",
                     count, enq_ready, deq_data);
        end
        deq_ready = 1'b0;
        tick();
        enq_valid = 1'b0;
        n_cmp++;
        if (count !== 3'd4 || act_st() !== exp_st()) begin
            n_bad++;
            $display("FAIL full_reoffer: got %b want %b", act_st(), exp_st());
        end
    endtask

    task automatic test_empty_enq();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        enq_valid = 1'b1;
        enq_data = 8'h5A;
        deq_ready = 1'b1;
        tick();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        n_cmp++;
        if (deq_valid !== 1'b1 || deq_data !== 8'h5A || count !== 3'd1) begin
            n_bad++;
            $display("FAIL empty_enq: valid=%b data=%h count=%0d want 1 5a 1",
                     deq_valid, deq_data, count);
        end
    endtask

    task automatic test_clear(input bit use_rst);
        enq_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq_data = 8'(8'h30 + i);
            tick();
        end
        flush = !use_rst;
        rst = use_rst;
        enq_data = 8'h99;
        deq_ready = 1'b1;
        tick();
        flush = 1'b0;
        rst = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        n_cmp++;
        if (count !== 3'd0 || empty !== 1'b1 || enq_ready !== 1'b1
            || deq_data !== 8'h00) begin
            n_bad++;
            $display("FAIL clear_%0d: count=%0d empty=%b rdy=%b data=%h",
                     use_rst, count, empty, enq_ready, deq_data);
        end
        enq_valid = 1'b1;
        enq_data = 8'h77;
        tick();
        enq_valid = 1'b0;
        n_cmp++;
        if (deq_data !== 8'h77 || count !== 3'd1) begin
            n_bad++;
            $display("FAIL clear_reenq_%0d: data=%h count=%0d want 77 1",
                     use_rst, deq_data, count);
        end
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            enq_valid = ($urandom_range(0, 3) != 0);
            deq_ready = ($urandom_range(0, 2) != 0);
            enq_data = 8'($urandom);
            flush = ($urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 90) == 0);
            tick();
            n_cmp++;
            if (act_st() !== exp_st()) begin
                n_bad++;
                $display("FAIL random_%0d: got %b want %b", i, act_st(), exp_st());
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle_inputs();
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_full_deq();
        test_empty_enq();
        test_clear(1'b0);
        test_clear(1'b1);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
